// File: rtl/otf_converter_hd.sv
// On-the-fly converter: turns an MSD-first signed-digit stream into an N+1-bit
// two's-complement word using Q/QM registers. Optional sticky err port: OTF_DIGIT_ERR_EN.
module otf_converter_hd #(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic         clk,
  input  logic         asyn_reset,
  input  logic [1:0]   din,
  input  logic         din_vld,
  output logic         din_rdy,
  output logic [N:0]   dout,
  output logic         dout_vld,
  input  logic         dout_rdy,
  output logic         busy
`ifdef OTF_DIGIT_ERR_EN
  ,
  output logic         err
`endif
);

  localparam int W = N + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    DIG_ZERO = 2'b00,
    DIG_POS  = 2'b01,
    DIG_ILL  = 2'b10,
    DIG_NEG  = 2'b11
  } digit_e;

  state_e          state_q, state_d;
  logic [W-1:0]    q_q, q_d;
  logic [W-1:0]    qm_q, qm_d;
  logic [W-1:0]    dout_q, dout_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    q_sh, qm_sh;
  logic            accept;

  assign accept = din_vld && (state_q == ACCUM);
  assign q_sh   = q_q << 1;
  assign qm_sh  = qm_q << 1;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    q_d     = q_q;
    qm_d    = qm_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;

    unique case (state_q)
      ACCUM: begin
        if (din_vld) begin
          unique case (digit_e'(din))
            DIG_POS: begin
              q_d  = q_sh | W'(1);
              qm_d = q_sh;
            end
            DIG_NEG: begin
              q_d  = qm_sh | W'(1);
              qm_d = qm_sh;
            end
            default: begin
              // Zero, and the illegal code which is folded onto zero.
              q_d  = q_sh;
              qm_d = qm_sh | W'(1);
            end
          endcase

          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            dout_d  = q_d;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      HOLD: begin
        // No digit is taken in HOLD, even when the word leaves this cycle.
        if (dout_rdy) begin
          state_d = ACCUM;
          q_d     = '0;
          qm_d    = '1;
        end
      end

      default: state_d = ACCUM;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      state_q <= ACCUM;
      q_q     <= '0;
      qm_q    <= '1;
      cnt_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      qm_q    <= qm_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end

`ifdef OTF_DIGIT_ERR_EN
  logic err_q;

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      err_q <= 1'b0;
    end else if (accept && (digit_e'(din) == DIG_ILL)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`endif

  assign din_rdy  = (state_q == ACCUM) && !asyn_reset;
  assign dout_vld = (state_q == HOLD);
  assign dout     = dout_q;
  assign busy     = (state_q == ACCUM) && (cnt_q != '0);

endmodule

// File: tb/tb_otf_converter_hd.sv
// Directed bench for otf_converter_hd with N=4; covers the OTF_DIGIT_ERR_EN port when defined.
module tb_otf_converter_hd;

  localparam int N  = 4;
  localparam int CW = 3;

  logic         clk = 1'b0;
  logic         asyn_reset;
  logic [1:0]   din;
  logic         din_vld;
  logic         din_rdy;
  logic [N:0]   dout;
  logic         dout_vld;
  logic         dout_rdy;
  logic         busy;
`ifdef OTF_DIGIT_ERR_EN
  logic         err;
`endif

  int total = 0;
  int bad   = 0;

  otf_converter_hd #(.N(N), .CW(CW)) dut (
    .clk        (clk),
    .asyn_reset (asyn_reset),
    .din        (din),
    .din_vld    (din_vld),
    .din_rdy    (din_rdy),
    .dout       (dout),
    .dout_vld   (dout_vld),
    .dout_rdy   (dout_rdy),
    .busy       (busy)
`ifdef OTF_DIGIT_ERR_EN
    ,
    .err        (err)
`endif
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic test_reset();
    asyn_reset = 1'b1;
    din        = 2'b00;
    din_vld    = 1'b0;
    dout_rdy   = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (dout_vld !== 1'b0) begin bad++; $display("FAIL reset_vld: got %b want 0", dout_vld); end
    total++; if (dout !== 5'b00000) begin bad++; $display("FAIL reset_dout: got %b want 00000", dout); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
`ifdef OTF_DIGIT_ERR_EN
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
`endif
    asyn_reset = 1'b0;
    @(negedge clk);
    total++; if (din_rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy: got %b want 1", din_rdy); end
    total++; if (dout_vld !== 1'b0) begin bad++; $display("FAIL reset_vld_post: got %b want 0", dout_vld); end
  endtask

  // One word back-to-back with dout_rdy=1; digits packed MSD first in digs[7:6].
  task automatic test_word(input string name, input logic [7:0] digs, input logic [4:0] exp);
    dout_rdy = 1'b1;
    for (int i = 0; i < N; i++) begin
      logic eb;
      eb = (i != 0);
      @(negedge clk);
      total++; if (dout_vld !== 1'b0) begin bad++; $display("FAIL %s vld_early[%0d]: got %b want 0", name, i, dout_vld); end
      total++; if (busy !== eb) begin bad++; $display("FAIL %s busy[%0d]: got %b want %b", name, i, busy, eb); end
      din     = digs[7-2*i -: 2];
      din_vld = 1'b1;
    end
    @(negedge clk);
    din_vld = 1'b0;
    total++; if (dout_vld !== 1'b1) begin bad++; $display("FAIL %s vld: got %b want 1", name, dout_vld); end
    total++; if (dout !== exp) begin bad++; $display("FAIL %s dout: got %b want %b", name, dout, exp); end
    total++; if (din_rdy !== 1'b0) begin bad++; $display("FAIL %s rdy_hold: got %b want 0", name, din_rdy); end
    @(negedge clk);
    total++; if (dout_vld !== 1'b0) begin bad++; $display("FAIL %s vld_one_cycle: got %b want 0", name, dout_vld); end
    total++; if (din_rdy !== 1'b1) begin bad++; $display("FAIL %s rdy_back: got %b want 1", name, din_rdy); end
    total++; if (dout !== exp) begin bad++; $display("FAIL %s dout_kept: got %b want %b", name, dout, exp); end
  endtask

  task automatic test_back_to_back();
    test_word("b2b_7",    8'b01_00_11_01, 5'b00111);
    test_word("neg_15",   8'b11_11_11_11, 5'b10001);
    test_word("pos_15",   8'b01_01_01_01, 5'b01111);
    test_word("zero",     8'b00_00_00_00, 5'b00000);
  endtask

  // Digits -1,0,+1,0 give -8+2 = -6; digits offered during HOLD must be ignored.
  task automatic test_backpressure();
    logic [7:0] digs;
    digs     = 8'b11_00_01_00;
    dout_rdy = 1'b0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      din     = digs[7-2*i -: 2];
      din_vld = 1'b1;
    end
    @(negedge clk);
    din     = 2'b01;
    for (int k = 0; k < 3; k++) begin
      total++; if (dout_vld !== 1'b1) begin bad++; $display("FAIL bp_vld[%0d]: got %b want 1", k, dout_vld); end
      total++; if (dout !== 5'b11010) begin bad++; $display("FAIL bp_dout[%0d]: got %b want 11010", k, dout); end
      total++; if (din_rdy !== 1'b0) begin bad++; $display("FAIL bp_rdy[%0d]: got %b want 0", k, din_rdy); end
      @(negedge clk);
    end
    dout_rdy = 1'b1;
    total++; if (din_rdy !== 1'b0) begin bad++; $display("FAIL bp_rdy_release: got %b want 0", din_rdy); end
    din_vld = 1'b0;
    @(negedge clk);
    total++; if (dout_vld !== 1'b0) begin bad++; $display("FAIL bp_vld_fall: got %b want 0", dout_vld); end
    total++; if (din_rdy !== 1'b1) begin bad++; $display("FAIL bp_rdy_back: got %b want 1", din_rdy); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_no_leak: got busy=%b want 0", busy); end
  endtask

  // Valid pattern 1,0,0,1,1,0,1 carrying +1,+1,-1,0 -> 8+4-2+0 = 10.
  task automatic test_bubbles();
    logic [6:0] vpat;
    logic [7:0] digs;
    int         n_acc;
    vpat     = 7'b1001101;
    digs     = 8'b01_01_11_00;
    n_acc    = 0;
    dout_rdy = 1'b1;
    for (int j = 0; j < 7; j++) begin
      logic eb;
      eb = (n_acc != 0);
      @(negedge clk);
      total++; if (busy !== eb) begin bad++; $display("FAIL bub_busy[%0d]: got %b want %b", j, busy, eb); end
      total++; if (dout_vld !== 1'b0) begin bad++; $display("FAIL bub_vld_early[%0d]: got %b want 0", j, dout_vld); end
      din_vld = vpat[6-j];
      if (vpat[6-j]) begin
        din   = digs[7-2*n_acc -: 2];
        n_acc = n_acc + 1;
      end else begin
        din = 2'b01;
      end
    end
    @(negedge clk);
    din_vld = 1'b0;
    total++; if (dout_vld !== 1'b1) begin bad++; $display("FAIL bub_vld: got %b want 1", dout_vld); end
    total++; if (dout !== 5'b01010) begin bad++; $display("FAIL bub_dout: got %b want 01010", dout); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bub_busy_hold: got %b want 0", busy); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_word();
    dout_rdy = 1'b1;
    @(negedge clk); din = 2'b01; din_vld = 1'b1;
    @(negedge clk); din = 2'b01; din_vld = 1'b1;
    @(negedge clk);
    din_vld = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b want 1", busy); end
    asyn_reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy_rst: got %b want 0", busy); end
    total++; if (dout_vld !== 1'b0) begin bad++; $display("FAIL mid_vld_rst: got %b want 0", dout_vld); end
    @(negedge clk);
    asyn_reset = 1'b0;
    @(negedge clk);
    total++; if (dout_vld !== 1'b0) begin bad++; $display("FAIL mid_vld_after: got %b want 0", dout_vld); end
`ifdef OTF_DIGIT_ERR_EN
    total++; if (err !== 1'b0) begin bad++; $display("FAIL mid_err_cleared: got %b want 0", err); end
`endif
    test_word("after_mid_rst", 8'b00_00_00_01, 5'b00001);
  endtask

  task automatic test_reset_in_hold();
    dout_rdy = 1'b0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk); din = 2'b01; din_vld = 1'b1;
    end
    @(negedge clk);
    din_vld = 1'b0;
    total++; if (dout_vld !== 1'b1) begin bad++; $display("FAIL hold_vld: got %b want 1", dout_vld); end
    asyn_reset = 1'b1;
    #1;
    total++; if (dout_vld !== 1'b0) begin bad++; $display("FAIL hold_vld_rst: got %b want 0", dout_vld); end
    total++; if (dout !== 5'b00000) begin bad++; $display("FAIL hold_dout_rst: got %b want 00000", dout); end
    @(negedge clk);
    asyn_reset = 1'b0;
    dout_rdy   = 1'b1;
    @(negedge clk);
    total++; if (dout_vld !== 1'b0) begin bad++; $display("FAIL hold_vld_after: got %b want 0", dout_vld); end
    total++; if (din_rdy !== 1'b1) begin bad++; $display("FAIL hold_rdy_after: got %b want 1", din_rdy); end
  endtask

  // +1, illegal, 0, 0 -> illegal folds onto 0, giving 8.
  task automatic test_illegal_digit();
    logic [7:0] digs;
    digs     = 8'b01_10_00_00;
    dout_rdy = 1'b1;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
`ifdef OTF_DIGIT_ERR_EN
      begin
        logic ee;
        ee = (i >= 2);
        total++; if (err !== ee) begin bad++; $display("FAIL ill_err[%0d]: got %b want %b", i, err, ee); end
      end
`endif
      din     = digs[7-2*i -: 2];
      din_vld = 1'b1;
    end
    @(negedge clk);
    din_vld = 1'b0;
    total++; if (dout_vld !== 1'b1) begin bad++; $display("FAIL ill_vld: got %b want 1", dout_vld); end
    total++; if (dout !== 5'b01000) begin bad++; $display("FAIL ill_dout: got %b want 01000", dout); end
    @(negedge clk);
    test_word("after_ill", 8'b00_00_00_00, 5'b00000);
`ifdef OTF_DIGIT_ERR_EN
    total++; if (err !== 1'b1) begin bad++; $display("FAIL ill_err_sticky: got %b want 1", err); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_bubbles();
    test_illegal_digit();
    test_reset_mid_word();
    test_reset_in_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
